// File: rtl/ntt_pkg.sv
// Shared constants and scheduler state encoding for the NTT polyvec datapath.
package ntt_pkg;

  localparam int unsigned NTT_N       = 256;
  localparam int unsigned KYBER_Q     = 3329;
  localparam int          KYBER_Q_INV = -3327;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first set req bit at or after ptr, wrapping at NUM_REQ.
import ntt_pkg::*;

module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] slot;

  always_comb begin
    win_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    slot    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      // ptr is always < NUM_REQ, so one conditional subtract is a full modulo
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      slot = pos[IDX_W-1:0];
      if (!valid_o && req_i[slot]) begin
        valid_o     = 1'b1;
        win_o[slot] = 1'b1;
        idx_o       = slot;
      end
    end
  end

endmodule

// File: rtl/ntt_rr_sched.sv
// Round-robin scheduler sharing one ntt core among NUM_REQ requesters.
// Optional watchdog (S_ERR, sticky err) is built when NTT_SCHED_TIMEOUT_EN is defined.
import ntt_pkg::*;

module ntt_rr_sched #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               ntt_start,
  input  logic               ntt_done,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy,
  output logic               err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("ntt_rr_sched: illegal parameter combination");
  end

  sched_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   ptr_next;

  logic [NUM_REQ-1:0] arb_win;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

`ifdef NTT_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (arb_win),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Pointer moves just past the requester being served
  assign ptr_next = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef NTT_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef NTT_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef NTT_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_win;
          sel_d   = arb_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef NTT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (ntt_done) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end
`ifdef NTT_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          gnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
`ifdef NTT_SCHED_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ack is combinational so the requester captures r_out in the done cycle
  always_comb begin
    ntt_start = (state_q == S_START);
    busy      = (state_q != S_IDLE);
    ack       = (state_q == S_WAIT && ntt_done) ? gnt_q : '0;
  end

  assign gnt = gnt_q;
  assign sel = sel_q;
`ifdef NTT_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
